// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared widths and limits for the register file and its scoreboard
package regfile_sb_pkg;
    localparam int XLEN          = 32;
    localparam int REG_IDX_WIDTH = 5;
    localparam int NUM_REGS      = 32;
    localparam int SB_CNT_WIDTH  = 2;
endpackage

// File: rtl/regfile_sb_cnt.sv
// rtl/regfile_sb_cnt.sv - per-register saturating pending-write counter with flush clear
module sb_cnt
    import regfile_sb_pkg::*;
#(
    parameter int CNT_W = SB_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_flush,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    // Saturate at both ends: an untracked WB write must not wrap to max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_flush) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with WB bypass and pending-write scoreboard
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int NUM_REGS = regfile_sb_pkg::NUM_REGS,
    parameter int CNT_W    = SB_CNT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     id_rs1_ren_i,
    input  logic [REG_IDX_WIDTH-1:0] id_rs1_idx_i,
    input  logic                     id_rs2_ren_i,
    input  logic [REG_IDX_WIDTH-1:0] id_rs2_idx_i,
    output logic [XLEN-1:0]          id_rs1_rdata_o,
    output logic [XLEN-1:0]          id_rs2_rdata_o,
    input  logic                     id_issue_i,
    input  logic                     id_rd_en_i,
    input  logic [REG_IDX_WIDTH-1:0] id_rd_idx_i,
    output logic                     sb_stall_o,
    input  logic                     wb_rd_en_i,
    input  logic [REG_IDX_WIDTH-1:0] wb_rd_idx_i,
    input  logic [XLEN-1:0]          wb_rd_wdata_i,
    input  logic                     flush_i
);

    logic [XLEN-1:0]     r_regs [1:NUM_REGS-1];
    logic [CNT_W-1:0]    w_cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] w_inc;
    logic [NUM_REGS-1:0] w_dec;
    logic [CNT_W-1:0]    w_eff_rs1;
    logic [CNT_W-1:0]    w_eff_rs2;
    logic [CNT_W-1:0]    w_eff_rd;

    assign w_cnt[0] = '0;
    assign w_inc[0] = 1'b0;
    assign w_dec[0] = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        assign w_inc[g] = id_issue_i && id_rd_en_i && (id_rd_idx_i == REG_IDX_WIDTH'(g));
        assign w_dec[g] = wb_rd_en_i && (wb_rd_idx_i == REG_IDX_WIDTH'(g));

        sb_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_inc   (w_inc[g]),
            .i_dec   (w_dec[g]),
            .i_flush (flush_i),
            .o_cnt   (w_cnt[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_rd_en_i && (wb_rd_idx_i != '0)) begin
            r_regs[wb_rd_idx_i] <= wb_rd_wdata_i;
        end
    end

    // The retiring WB write is bypassed, so it no longer counts as in flight.
    function automatic logic [CNT_W-1:0] eff_cnt(input logic [CNT_W-1:0] cnt, input logic dec);
        return (dec && (cnt != '0)) ? cnt - CNT_W'(1) : cnt;
    endfunction

    function automatic logic [XLEN-1:0] read_mux(input logic [REG_IDX_WIDTH-1:0] idx,
                                                 input logic [XLEN-1:0]          arr);
        if (idx == '0) begin
            return '0;
        end else if (wb_rd_en_i && (wb_rd_idx_i == idx)) begin
            return wb_rd_wdata_i;
        end
        return arr;
    endfunction

    always_comb begin
        id_rs1_rdata_o = read_mux(id_rs1_idx_i, r_regs[id_rs1_idx_i]);
        id_rs2_rdata_o = read_mux(id_rs2_idx_i, r_regs[id_rs2_idx_i]);
    end

    always_comb begin
        w_eff_rs1  = eff_cnt(w_cnt[id_rs1_idx_i], w_dec[id_rs1_idx_i]);
        w_eff_rs2  = eff_cnt(w_cnt[id_rs2_idx_i], w_dec[id_rs2_idx_i]);
        w_eff_rd   = eff_cnt(w_cnt[id_rd_idx_i],  w_dec[id_rd_idx_i]);
        sb_stall_o = (id_rs1_ren_i && (w_eff_rs1 != '0))
                   | (id_rs2_ren_i && (w_eff_rs2 != '0))
                   | (id_rd_en_i && (id_rd_idx_i != '0) && (w_eff_rd == '1));
    end

    a_no_issue_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
        !(id_issue_i && sb_stall_o));

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard-driven self-checking bench for regfile_sb
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_rs1_ren_i, id_rs2_ren_i, id_issue_i, id_rd_en_i, wb_rd_en_i, flush_i;
    logic [4:0]  id_rs1_idx_i, id_rs2_idx_i, id_rd_idx_i, wb_rd_idx_i;
    logic [31:0] wb_rd_wdata_i;
    logic [31:0] id_rs1_rdata_o, id_rs2_rdata_o;
    logic        sb_stall_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_regs [32];
    int          m_cnt  [32];
    logic [31:0] q_exp  [$];

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1_ren_i   (id_rs1_ren_i),
        .id_rs1_idx_i   (id_rs1_idx_i),
        .id_rs2_ren_i   (id_rs2_ren_i),
        .id_rs2_idx_i   (id_rs2_idx_i),
        .id_rs1_rdata_o (id_rs1_rdata_o),
        .id_rs2_rdata_o (id_rs2_rdata_o),
        .id_issue_i     (id_issue_i),
        .id_rd_en_i     (id_rd_en_i),
        .id_rd_idx_i    (id_rd_idx_i),
        .sb_stall_o     (sb_stall_o),
        .wb_rd_en_i     (wb_rd_en_i),
        .wb_rd_idx_i    (wb_rd_idx_i),
        .wb_rd_wdata_i  (wb_rd_wdata_i),
        .flush_i        (flush_i)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int m_eff(input int r, input logic wben, input logic [4:0] wbi);
        if (r == 0) return 0;
        return m_cnt[r] - ((wben && wbi == r && m_cnt[r] > 0) ? 1 : 0);
    endfunction

    function automatic logic m_stall(input logic r1en, input logic [4:0] r1, input logic r2en,
                                     input logic [4:0] r2, input logic rden, input logic [4:0] rd,
                                     input logic wben, input logic [4:0] wbi);
        return (r1en && m_eff(r1, wben, wbi) != 0) || (r2en && m_eff(r2, wben, wbi) != 0)
            || (rden && rd != 0 && m_eff(rd, wben, wbi) == 3);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic wben,
                                           input logic [4:0] wbi, input logic [31:0] wbd);
        if (idx == 0) return 32'h0;
        if (wben && wbi == idx) return wbd;
        return m_regs[idx];
    endfunction

    task automatic step(input string tag, input logic r1en, input logic [4:0] r1,
                        input logic r2en, input logic [4:0] r2, input logic iss,
                        input logic rden, input logic [4:0] rd, input logic wben,
                        input logic [4:0] wbi, input logic [31:0] wbd, input logic fl);
        @(negedge clk);
        id_rs1_ren_i = r1en; id_rs1_idx_i = r1; id_rs2_ren_i = r2en; id_rs2_idx_i = r2;
        id_issue_i = iss; id_rd_en_i = rden; id_rd_idx_i = rd;
        wb_rd_en_i = wben; wb_rd_idx_i = wbi; wb_rd_wdata_i = wbd; flush_i = fl;
        q_exp.push_back(m_read(r1, wben, wbi, wbd));
        q_exp.push_back(m_read(r2, wben, wbi, wbd));
        q_exp.push_back({31'd0, m_stall(r1en, r1, r2en, r2, rden, rd, wben, wbi)});
        #2;
        chk({tag, ".rs1"},   id_rs1_rdata_o, q_exp.pop_front());
        chk({tag, ".rs2"},   id_rs2_rdata_o, q_exp.pop_front());
        chk({tag, ".stall"}, {31'd0, sb_stall_o}, q_exp.pop_front());
        @(posedge clk);
        if (wben && wbi != 0) m_regs[wbi] = wbd;
        for (int r = 1; r < 32; r++) begin
            logic inc, dec;
            inc = iss && rden && rd == r;
            dec = wben && wbi == r;
            if (fl) m_cnt[r] = 0;
            else if (inc && !dec && m_cnt[r] < 3) m_cnt[r]++;
            else if (dec && !inc && m_cnt[r] > 0) m_cnt[r]--;
        end
    endtask

    task automatic idle_inputs();
        id_rs1_ren_i = 0; id_rs1_idx_i = 0; id_rs2_ren_i = 0; id_rs2_idx_i = 0;
        id_issue_i = 0; id_rd_en_i = 0; id_rd_idx_i = 0;
        wb_rd_en_i = 0; wb_rd_idx_i = 0; wb_rd_wdata_i = 0; flush_i = 0;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin m_regs[r] = 0; m_cnt[r] = 0; end
        idle_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1;

        //        tag      r1en r1 r2en r2 iss rden rd wben wbi wbd           fl
        step("rst_rd",     1, 5,  1, 0,  0, 0, 0,  0, 0,  32'h0,        0);
        step("wb_x0",      1, 0,  0, 0,  0, 0, 0,  1, 0,  32'hDEADBEEF, 0);
        step("rd_x0",      1, 0,  1, 0,  0, 0, 0,  0, 0,  32'h0,        0);
        step("byp_x3",     1, 3,  0, 0,  0, 0, 0,  1, 3,  32'h1234,     0);
        step("arr_x3",     1, 3,  1, 3,  0, 0, 0,  0, 0,  32'h0,        0);
        step("iss_x7",     0, 0,  0, 0,  1, 1, 7,  0, 0,  32'h0,        0);
        step("raw_x7",     1, 7,  0, 0,  0, 0, 0,  0, 0,  32'h0,        0);
        step("wb_x7",      1, 7,  0, 0,  0, 0, 0,  1, 7,  32'h55,       0);
        repeat (3) step("iss_x4", 0, 0, 0, 0, 1, 1, 4, 0, 0, 32'h0, 0);
        step("waw_x4",     0, 0,  0, 0,  0, 1, 4,  0, 0,  32'h0,        0);
        step("wbiss_x4",   0, 0,  0, 0,  1, 1, 4,  1, 4,  32'h44,       0);
        step("still_x4",   0, 0,  0, 0,  0, 1, 4,  0, 0,  32'h0,        0);
        step("iss_x9",     0, 0,  0, 0,  1, 1, 9,  0, 0,  32'h0,        0);
        step("both_x9",    0, 0,  0, 0,  1, 1, 9,  1, 9,  32'h99,       0);
        step("raw_x9",     1, 9,  0, 0,  0, 0, 0,  0, 0,  32'h0,        0);
        step("iss_x2a",    0, 0,  0, 0,  1, 1, 2,  0, 0,  32'h0,        0);
        step("iss_x2b",    0, 0,  0, 0,  1, 1, 2,  0, 0,  32'h0,        0);
        step("flush_x2",   0, 0,  1, 2,  0, 0, 0,  1, 2,  32'hA,        1);
        step("post_fl",    1, 2,  1, 4,  0, 1, 4,  0, 0,  32'h0,        0);

        for (int n = 0; n < 300; n++) begin
            logic [4:0] r1, r2, rd, wbi;
            logic       r1en, r2en, rden, iss, wben;
            r1 = 5'($urandom_range(0, 31)); r2 = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31)); wbi = 5'($urandom_range(0, 31));
            r1en = 1'($urandom); r2en = 1'($urandom); rden = 1'($urandom);
            wben = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 4; k++) begin
                logic [4:0] c;
                c = 5'($urandom_range(1, 31));
                if (m_cnt[c] > 0) wbi = c;
            end
            iss = rden && $urandom_range(0, 1) && !m_stall(r1en, r1, r2en, r2, rden, rd, wben, wbi);
            step("rand", r1en, r1, r2en, r2, iss, rden, rd, wben, wbi, $urandom,
                 ($urandom_range(0, 40) == 0));
        end

        step("pre_rst",    0, 0,  0, 0,  1, 1, 6,  1, 6,  32'h66,       0);
        step("pre_rst2",   0, 0,  0, 0,  1, 1, 6,  0, 0,  32'h0,        0);
        @(negedge clk);
        idle_inputs();
        #2 rst_n = 0;
        id_rs1_ren_i = 1; id_rs1_idx_i = 6; id_rs2_ren_i = 1; id_rs2_idx_i = 3;
        #1;
        chk("async_rst.rs1",   id_rs1_rdata_o, 32'h0);
        chk("async_rst.rs2",   id_rs2_rdata_o, 32'h0);
        chk("async_rst.stall", {31'd0, sb_stall_o}, 32'h0);
        for (int r = 0; r < 32; r++) begin m_regs[r] = 0; m_cnt[r] = 0; end
        idle_inputs();
        @(negedge clk) rst_n = 1;
        step("after_rst",  1, 6,  1, 3,  0, 1, 6,  0, 0,  32'h0,        0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
